// File: rtl/decrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : decrypt_core
// Purpose  : Iterative AES-128 decryption core with on-chip key expansion.
// Revision : 1.0 - initial release
// ============================================================================
module decrypt_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key,
  input  logic         start,
  input  logic [127:0] in,
  output logic         ready,
  output logic [127:0] out,
  output logic         out_valid
);

  typedef enum logic [1:0] {NOKEY = 2'd0, KEYEXP = 2'd1, IDLE = 2'd2, DEC = 2'd3} state_t;

  localparam logic [3:0] c_LAST_RK = 4'd10;

  // GF(2^8) arithmetic; S-boxes are derived from the field inverse plus affine map
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240;
    a2   = gmul(a, a);
    a3   = gmul(a2, a);
    a12  = gmul(gmul(a3, a3), gmul(a3, a3));
    a15  = gmul(a12, a3);
    a240 = gmul(a15, a15);
    a240 = gmul(a240, a240);
    a240 = gmul(a240, a240);
    a240 = gmul(a240, a240);
    return gmul(gmul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++)
      o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t       r_fsm;
  state_t       w_fsm_next;
  logic [3:0]   r_kidx;
  logic [3:0]   r_round;
  logic [127:0] r_state;
  logic [127:0] r_out;
  logic         r_out_valid;
  logic [127:0] r_rk [0:10];

  logic         w_key_acc;
  logic         w_start_acc;
  logic [127:0] w_rk_next;
  logic [127:0] w_ark;
  logic [127:0] w_imc;

  assign ready       = (r_fsm == NOKEY) || (r_fsm == IDLE);
  assign w_key_acc   = ready && key_load;
  assign w_start_acc = (r_fsm == IDLE) && start && !key_load;
  assign w_rk_next   = next_rk(r_rk[r_kidx - 4'd1], rcon(r_kidx));
  assign w_ark       = inv_sub_bytes(inv_shift_rows(r_state)) ^ r_rk[r_round];
  assign w_imc       = inv_mix_columns(w_ark);
  assign out         = r_out;
  assign out_valid   = r_out_valid;

  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      NOKEY:   if (key_load) w_fsm_next = KEYEXP;
      KEYEXP:  if (r_kidx == c_LAST_RK) w_fsm_next = IDLE;
      IDLE: begin
        if (key_load)   w_fsm_next = KEYEXP;
        else if (start) w_fsm_next = DEC;
      end
      DEC:     if (r_round == 4'd0) w_fsm_next = IDLE;
      default: w_fsm_next = NOKEY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= NOKEY;
      r_kidx      <= 4'd0;
      r_round     <= 4'd0;
      r_state     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_next;
      r_out_valid <= 1'b0;
      if (w_key_acc)
        r_kidx <= 4'd1;
      else if (r_fsm == KEYEXP)
        r_kidx <= r_kidx + 4'd1;
      if (w_start_acc) begin
        r_state <= in ^ r_rk[c_LAST_RK];
        r_round <= 4'd9;
      end else if (r_fsm == DEC) begin
        if (r_round != 4'd0) begin
          r_state <= w_imc;
          r_round <= r_round - 4'd1;
        end else begin
          r_out       <= w_ark;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  // Key storage needs no reset: NOKEY blocks any use until a fresh expansion
  always_ff @(posedge clk) begin
    if (w_key_acc)
      r_rk[0] <= key;
    else if (r_fsm == KEYEXP)
      r_rk[r_kidx] <= w_rk_next;
  end

endmodule
`default_nettype wire

// File: tb/tb_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_decrypt_core
// Purpose  : Directed self-checking bench for decrypt_core (FIPS-197 vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decrypt_core;

  localparam logic [127:0] c_KEY_A  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] c_CT_A   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] c_PT_A   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] c_RK10_A = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] c_KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] c_CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] c_PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] c_RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] c_CT_C   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] c_PT_C   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] c_CT_D   = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] c_PT_D   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_load = 1'b0;
  logic [127:0] key = '0;
  logic         start = 1'b0;
  logic [127:0] in = '0;
  logic         ready;
  logic [127:0] out;
  logic         out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  decrypt_core dut (
    .clk       (clk),
    .rst       (rst),
    .key_load  (key_load),
    .key       (key),
    .start     (start),
    .in        (in),
    .ready     (ready),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Ready must stay low for exactly 10 cycles after the accepting edge
  task automatic load_key(input logic [127:0] k, input logic [127:0] rk10, input string tag);
    int cnt;
    key_load = 1'b1;
    key      = k;
    @(negedge clk);
    key_load = 1'b0;
    key      = ~k;
    check({tag, "_ready_low"}, 128'(ready), 128'd0);
    cnt = 0;
    while (!ready && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_expand_cycles"}, 128'(cnt), 128'd10);
    check({tag, "_rk10"}, dut.r_rk[10], rk10);
  endtask

  task automatic decrypt(input logic [127:0] ct, input logic [127:0] pt, input string tag);
    int cnt;
    start = 1'b1;
    in    = ct;
    @(negedge clk);
    start = 1'b0;
    in    = ~ct;
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    // cnt edges have passed; the next edge is the one that samples out_valid
    check({tag, "_latency"}, 128'(cnt + 1), 128'd11);
    check({tag, "_out"}, out, pt);
    @(negedge clk);
    check({tag, "_pulse_width"}, 128'(out_valid), 128'd0);
    check({tag, "_out_hold"}, out, pt);
  endtask

  task automatic watch_nokey(input int n, input string tag);
    int nv;
    int nr;
    nv = 0;
    nr = 0;
    for (int i = 0; i < n; i++) begin
      start = (i % 3 == 0);
      in    = c_CT_A;
      @(negedge clk);
      if (out_valid) nv++;
      if (!ready) nr++;
    end
    start = 1'b0;
    check({tag, "_no_valid"}, 128'(nv), 128'd0);
    check({tag, "_ready_high"}, 128'(nr), 128'd0);
    check({tag, "_out_zero"}, out, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int nv;
    int lat;
    int holdbad;
    logic [127:0] got;

    repeat (3) @(negedge clk);
    check("reset_ready", 128'(ready), 128'd1);
    check("reset_out", out, 128'd0);
    check("reset_valid", 128'(out_valid), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    watch_nokey(20, "nokey_start");

    load_key(c_KEY_A, c_RK10_A, "keyA");
    decrypt(c_CT_A, c_PT_A, "decA");
    load_key(c_KEY_B, c_RK10_B, "keyB");
    decrypt(c_CT_B, c_PT_B, "decB");

    // key_load and start together in IDLE: key wins, start dropped
    key_load = 1'b1;
    key      = c_KEY_B;
    start    = 1'b1;
    in       = c_CT_B;
    @(negedge clk);
    key_load = 1'b0;
    start    = 1'b0;
    cnt = 0;
    nv  = 0;
    while (!ready && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (out_valid) nv++;
    end
    repeat (5) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("both_ready_low_cycles", 128'(cnt), 128'd10);
    check("both_no_valid", 128'(nv), 128'd0);

    // Commands during DEC are ignored
    start = 1'b1;
    in    = c_CT_B;
    @(negedge clk);
    start = 1'b0;
    in    = '0;
    nv  = 0;
    lat = 0;
    got = '0;
    for (int i = 1; i <= 25; i++) begin
      start    = (i == 3);
      in       = c_CT_C;
      key_load = (i == 6);
      key      = c_KEY_A;
      @(negedge clk);
      if (out_valid) begin
        nv++;
        if (lat == 0) lat = i + 1;
        got = out;
      end
    end
    check("busy_one_valid", 128'(nv), 128'd1);
    check("busy_latency", 128'(lat), 128'd11);
    check("busy_out", got, c_PT_B);
    check("busy_rk10_kept", dut.r_rk[10], c_RK10_B);

    // Back-to-back: second start in the out_valid cycle
    start = 1'b1;
    in    = c_CT_C;
    @(negedge clk);
    start = 1'b0;
    in    = '0;
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b_first_out", out, c_PT_C);
    start = 1'b1;
    in    = c_CT_D;
    cnt     = 0;
    holdbad = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      in    = '0;
      cnt++;
      if (!out_valid && out !== c_PT_C) holdbad++;
    end while (!out_valid && cnt < 40);
    check("b2b_spacing", 128'(cnt), 128'd11);
    check("b2b_hold_first", 128'(holdbad), 128'd0);
    check("b2b_second_out", out, c_PT_D);

    // Reset in the middle of a decryption
    @(negedge clk);
    start = 1'b1;
    in    = c_CT_B;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out", out, 128'd0);
    check("midrst_valid", 128'(out_valid), 128'd0);
    check("midrst_ready", 128'(ready), 128'd1);
    check("midrst_state_reg", dut.r_state, 128'd0);
    check("midrst_round", 128'(dut.r_round), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_nokey(20, "postrst_start");

    load_key(c_KEY_B, c_RK10_B, "keyB2");
    decrypt(c_CT_B, c_PT_B, "decB2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decrypt_core.md
DECRYPT_CORE -- requirements
Module: decrypt_core

Interface
REQ-001 The block SHALL have no parameters; AES-128 only, Nr = 10 fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 key_load  input  1  request to load and expand a new cipher key.
REQ-005 key  input  128  AES-128 cipher key, sampled with key_load.
REQ-006 start  input  1  request to decrypt one block.
REQ-007 in  input  128  ciphertext block, sampled with start.
REQ-008 ready  output  1  high when key_load or start can be accepted.
REQ-009 out  output  128  plaintext block, registered, held until the next result.
REQ-010 out_valid  output  1  one-cycle pulse marking a new out value.
REQ-011 All 128-bit buses SHALL use FIPS-197 byte order: byte 0 at [127:120], column-major state.

Function
REQ-012 The FSM SHALL have states NOKEY, KEYEXP, IDLE and DEC.
REQ-013 ready SHALL be 1 in NOKEY and IDLE, and 0 in KEYEXP and DEC.
REQ-014 key_load sampled high in NOKEY or IDLE SHALL do all of the following:
- capture key as rk[0];
- enter KEYEXP;
- compute rk[1]..rk[10] one per cycle, with Rcon 01,02,04,08,10,20,40,80,1b,36;
- enter IDLE on the edge that writes rk[10], i.e. 10 cycles after the key_load edge.
REQ-015 Round keys SHALL be held in an internal 11x128 register array, retained until the next key_load or rst.
REQ-016 start sampled high in IDLE with key_load low SHALL load state = in XOR rk[10], set round counter r = 9 and enter DEC.
REQ-017 For r = 9..1, each DEC cycle SHALL compute state = InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR rk[r]), then decrement r.
REQ-018 The DEC cycle with r = 0 SHALL do all of the following:
- compute InvSubBytes(InvShiftRows(state)) XOR rk[0] (no InvMixColumns);
- write the result to out;
- assert out_valid in the following cycle;
- return to IDLE.
REQ-019 Latency: out_valid SHALL be high exactly 11 cycles after the start edge.
- Back-to-back throughput is one block per 11 cycles.
- start may be high in the same cycle as out_valid, because ready is already 1.
REQ-020 start in NOKEY SHALL be ignored: no state change, no out_valid.
REQ-021 key_load and start high together in IDLE: key_load SHALL win; start is dropped.
REQ-022 key_load or start while ready = 0 SHALL be ignored, with no effect on the operation in progress.
REQ-023 in and key SHALL be sampled only on the accepting edge; later changes have no effect.
REQ-024 out SHALL change only on the final DEC edge and SHALL otherwise hold its value.
REQ-025 Inverse S-box, InvShiftRows and InvMixColumns SHALL be exact FIPS-197 inverses of the team's existing encrypt-side transforms; the round datapath is combinational between state registers.

Reset
REQ-026 rst high SHALL immediately force:
- state NOKEY;
- ready = 1, out = 0, out_valid = 0;
- round counter 0, state register 0;
- all rk[] invalid (key must be reloaded).
REQ-027 rst asserted mid-KEYEXP or mid-DEC SHALL abort the operation with no out_valid pulse.
REQ-028 The first accepted command after rst deassertion SHALL be a key_load.

Verification
REQ-029 key_load with key = 000102030405060708090a0b0c0d0e0f, then after ready, start with in = 69c4e0d86a7b0430d8cdb78070b4c55a -> out = 00112233445566778899aabbccddeeff, out_valid 11 cycles after start.
REQ-030 key_load with key = 2b7e151628aed2a6abf7158809cf4f3c, then start with in = 3925841d02dc09fbdc118597196a0b32 -> out = 3243f6a8885a308d313198a2e0370734; also check rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-031 Start after rst with no key_load -> no out_valid for 20 cycles, ready stays 1, out = 0.
REQ-032 key_load and start together in IDLE -> key re-expands (ready low for 10 cycles), no out_valid; a second start pulse during DEC -> ignored, exactly one out_valid.
REQ-033 Two back-to-back blocks, the second start issued in the out_valid cycle -> two correct plaintexts 11 cycles apart, out holding the first until the second arrives.
REQ-034 rst pulsed at DEC cycle 5 -> no out_valid, out = 0, state NOKEY; a subsequent start is ignored until a new key_load.
